// File: rtl/pipe_ctrl_if.sv
// Stall/exception bundle between the pipeline stages and pipe_ctrl.
// The stages act as master: they raise requests and obey the returned stall/flush controls.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              excp_req;
  logic [31:0]       excp_handler;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              stall_timeout;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_handler,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_handler,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: stall vector, exception freeze/flush/refill recovery,
// stall watchdog and saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int STALL_LIMIT = 255,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int WD_W = $clog2(STALL_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIM  = WD_W'(STALL_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_LIMIT - 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_REFILL = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [5:0]       req_map;
  logic [5:0]       stall_d;
  logic             freeze;
  logic             count_en;
  logic [WD_W-1:0]  wd_cnt;
  logic             flush_q;
  logic [31:0]      new_pc_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cyc_q;

  // Highest requesting stage wins; it and everything upstream of it hold.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_map = 6'b000000;
    if      (bus.stallreq_mem) req_map = 6'b011111;
    else if (bus.stallreq_ex)  req_map = 6'b001111;
    else if (bus.stallreq_id)  req_map = 6'b000111;
    else if (bus.stallreq_if)  req_map = 6'b000011;
  end

  assign freeze = (state == ST_RUN) && bus.excp_req;

  always_comb begin
    stall_d = 6'b000000;
    if (!rst) begin
      case (state)
        ST_RUN:    stall_d = freeze ? 6'b111111 : req_map;
        ST_REFILL: stall_d = req_map;
        default:   stall_d = 6'b000000;
      endcase
    end
  end

  // The freeze cycle is excluded: exception handling is not a request-driven stall.
  assign count_en = !freeze && (state != ST_FLUSH) && (req_map != 6'b000000);

  always_comb begin
    state_nxt = ST_RUN;
    case (state)
      ST_RUN:    state_nxt = freeze ? ST_FLUSH : ST_RUN;
      ST_FLUSH:  state_nxt = ST_REFILL;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_q   <= 1'b0;
      new_pc_q  <= 32'h0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state   <= state_nxt;
      flush_q <= freeze;
      if (freeze) new_pc_q <= bus.excp_handler;

      if (count_en) begin
        if (wd_cnt != WD_LIM)   wd_cnt    <= wd_cnt + WD_W'(1);
        if (wd_cnt >= WD_LAST)  timeout_q <= 1'b1;
      end else if (!freeze) begin
        wd_cnt <= '0;
      end

      if (count_en && (cyc_q != {CNT_W{1'b1}})) cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign bus.stall         = stall_d;
  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.stall_cycles  = cyc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven stall map plus directed recovery,
// watchdog, saturation and reset sequences on two parameterisations.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus_a ();
  pipe_ctrl_if #(.CNT_W(3))  bus_b ();

  pipe_ctrl #(.STALL_LIMIT(255), .CNT_W(32)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  pipe_ctrl #(.STALL_LIMIT(4),   .CNT_W(3))  u_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  typedef struct {
    logic [3:0] req;   // {mem, ex, id, if}
    logic [5:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [3:0] r, input logic e, input logic [31:0] h);
    {bus_a.stallreq_mem, bus_a.stallreq_ex, bus_a.stallreq_id, bus_a.stallreq_if} = r;
    bus_a.excp_req     = e;
    bus_a.excp_handler = h;
  endtask

  task automatic set_b(input logic [3:0] r);
    {bus_b.stallreq_mem, bus_b.stallreq_ex, bus_b.stallreq_id, bus_b.stallreq_if} = r;
    bus_b.excp_req     = 1'b0;
    bus_b.excp_handler = 32'h0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    tick();
    tick();
    rst_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int exp_cnt;
    vecs[0] = '{4'b0000, 6'b000000};
    vecs[1] = '{4'b0001, 6'b000011};
    vecs[2] = '{4'b0010, 6'b000111};
    vecs[3] = '{4'b0100, 6'b001111};
    vecs[4] = '{4'b1000, 6'b011111};
    vecs[5] = '{4'b0011, 6'b000111};
    vecs[6] = '{4'b0101, 6'b001111};
    vecs[7] = '{4'b1110, 6'b011111};
    vecs[8] = '{4'b1111, 6'b011111};
    vecs[9] = '{4'b0000, 6'b000000};

    set_a(4'b0000, 1'b0, 32'h0);
    set_b(4'b0000);
    rst_b = 1'b1;
    reset_a();
    rst_b = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_stall",   bus_a.stall, 6'b0);
    check("rst_flush",   bus_a.flush, 1'b0);
    check("rst_new_pc",  bus_a.new_pc, 32'h0);
    check("rst_timeout", bus_a.stall_timeout, 1'b0);
    check("rst_cycles",  bus_a.stall_cycles, 32'd0);
    tick();

    // Stall map table
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_a(vecs[i].req, 1'b0, 32'h0);
      @(negedge clk);
      check($sformatf("map_%0d", i), bus_a.stall, vecs[i].exp);
      if (vecs[i].exp != 6'b0) exp_cnt++;
      tick();
    end
    check("map_cycles", bus_a.stall_cycles, 64'(exp_cnt));

    // Priority: if+ex for 3 cycles
    reset_a();
    for (int i = 0; i < 3; i++) begin
      set_a(4'b0101, 1'b0, 32'h0);
      @(negedge clk);
      check($sformatf("prio_stall_%0d", i), bus_a.stall, 6'b001111);
      tick();
    end
    set_a(4'b0000, 1'b0, 32'h0);
    check("prio_cycles", bus_a.stall_cycles, 32'd3);

    // Exception with mem stall; excp in FLUSH and REFILL ignored
    set_a(4'b1000, 1'b1, 32'h0000_0180);
    @(negedge clk);
    check("excp_freeze", bus_a.stall, 6'b111111);
    tick();
    check("excp_flush",  bus_a.flush, 1'b1);
    check("excp_new_pc", bus_a.new_pc, 32'h180);
    set_a(4'b1000, 1'b1, 32'h0000_0999);
    @(negedge clk);
    check("flush_stall", bus_a.stall, 6'b0);
    tick();
    check("refill_flush", bus_a.flush, 1'b0);
    set_a(4'b0000, 1'b1, 32'h0000_0999);
    @(negedge clk);
    check("refill_stall_idle", bus_a.stall, 6'b0);
    tick();
    check("refill_excp_ignored", bus_a.flush, 1'b0);
    check("excp_new_pc_held", bus_a.new_pc, 32'h180);
    check("excp_cycles", bus_a.stall_cycles, 32'd3);
    set_a(4'b0000, 1'b0, 32'h0);
    tick();

    // Stall request honoured in REFILL
    set_a(4'b0000, 1'b1, 32'h0000_0200);
    tick();
    set_a(4'b0000, 1'b0, 32'h0);
    tick();
    set_a(4'b0100, 1'b0, 32'h0);
    @(negedge clk);
    check("refill_stall_ex", bus_a.stall, 6'b001111);
    tick();
    set_a(4'b0000, 1'b0, 32'h0);
    check("refill_cycles", bus_a.stall_cycles, 32'd4);
    check("refill_wd", 64'(u_a.wd_cnt), 64'd1);
    tick();

    // Reset in FLUSH cycle
    set_a(4'b0000, 1'b1, 32'h0000_0300);
    tick();
    check("rr_flush_before", bus_a.flush, 1'b1);
    set_a(4'b1000, 1'b0, 32'h0);
    rst_a = 1'b1;
    @(negedge clk);
    check("rr_stall_forced", bus_a.stall, 6'b0);
    tick();
    rst_a = 1'b0;
    set_a(4'b0000, 1'b0, 32'h0);
    check("rr_flush",   bus_a.flush, 1'b0);
    check("rr_new_pc",  bus_a.new_pc, 32'h0);
    check("rr_cycles",  bus_a.stall_cycles, 32'd0);
    check("rr_timeout", bus_a.stall_timeout, 1'b0);
    set_a(4'b0000, 1'b1, 32'h0000_0400);
    @(negedge clk);
    check("rr_freeze", bus_a.stall, 6'b111111);
    tick();
    set_a(4'b0000, 1'b0, 32'h0);
    check("rr_flush_new",  bus_a.flush, 1'b1);
    check("rr_new_pc_new", bus_a.new_pc, 32'h400);
    tick();
    tick();

    // Watchdog, STALL_LIMIT=4: 3 on, 1 off, 4 on
    for (int i = 0; i < 3; i++) begin
      set_b(4'b1000);
      tick();
      check($sformatf("wd_a_%0d", i), bus_b.stall_timeout, 1'b0);
    end
    set_b(4'b0000);
    tick();
    check("wd_gap", bus_b.stall_timeout, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_b(4'b1000);
      @(negedge clk);
      check($sformatf("wd_b_stall_%0d", i), bus_b.stall, 6'b011111);
      tick();
      check($sformatf("wd_b_%0d", i), bus_b.stall_timeout, (i == 3) ? 1'b1 : 1'b0);
    end
    set_b(4'b0000);
    tick();
    tick();
    check("wd_sticky", bus_b.stall_timeout, 1'b1);

    // Saturation, CNT_W=3
    reset_b();
    check("sat_reset", bus_b.stall_cycles, 3'd0);
    for (int i = 0; i < 10; i++) begin
      set_b(4'b0010);
      tick();
      check($sformatf("sat_%0d", i), bus_b.stall_cycles, (i + 1 > 7) ? 64'd7 : 64'(i + 1));
    end
    set_b(4'b0000);
    tick();
    check("sat_hold", bus_b.stall_cycles, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control sequencer for the five-stage core. It collects stall requests from IF, ID, EX and MEM and drives the per-stage `stall` vector that every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register obey. It sequences exception recovery: freeze, then a one-cycle `flush` with a redirect PC, then a one-cycle refill guard. It also maintains a stall watchdog and a stall-cycle performance counter.

## Interface
- `STALL_LIMIT`, 255: count of consecutive request-driven stall cycles at which the watchdog fires.
- `CNT_W`, 32: width of the `stall_cycles` counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stallreq_if`  in  1  IF stage not ready, e.g. fetch bus wait.
- `stallreq_id`  in  1  ID stage load-use hazard.
- `stallreq_ex`  in  1  EX multi-cycle operation (mul/div) busy.
- `stallreq_mem`  in  1  MEM data bus wait.
- `excp_req`  in  1  exception detected on the instruction in MEM.
- `excp_handler`  in  32  handler address, valid when `excp_req`=1.
- `stall`  out  6  hold bits: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB (reserved, mirrors the rule).
- `flush`  out  1  clears every pipeline register to its reset/bubble value.
- `new_pc`  out  32  PC redirect target, valid while `flush`=1.
- `stall_timeout`  out  1  sticky watchdog flag.
- `stall_cycles`  out  CNT_W  saturating count of request-driven stall cycles.

## Operation
- **States:** RUN, FLUSH, REFILL. Reset state is RUN.
- **Request-to-vector map (RUN and REFILL)**, with the highest stage winning:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- **Bubble rule:** a pipeline register whose bit is 1 holds its contents. When its own bit is 0 but the bit of the stage feeding it is 1, it loads a bubble. The pipeline registers implement this; `pipe_ctrl` only drives the vector.
- **RUN + `excp_req`=1:**
  - `stall`=6'b111111 that cycle (full freeze); excp_req outranks all stall requests.
  - Latch `excp_handler` into `new_pc`.
  - Next state FLUSH.
- **FLUSH (exactly 1 cycle):**
  - `flush`=1, `stall`=0.
  - All stall requests and `excp_req` are ignored.
  - Next state REFILL.
- **REFILL (exactly 1 cycle):**
  - `excp_req` is ignored, which masks stale requests from flushed stages.
  - Stall requests are honoured per the map.
  - Next state RUN.
- **Watchdog:**
  - An internal counter increments each cycle the map output is nonzero in RUN or REFILL.
  - It clears on any cycle with map output zero, and in FLUSH.
  - The freeze cycle neither counts nor clears it.
  - When the counter reaches `STALL_LIMIT`, `stall_timeout` sets and stays 1 until `rst`.
  - The watchdog never alters `stall`.
- **`stall_cycles`:**
  - Increments on the same condition as the watchdog increment.
  - Saturates at all-ones and never wraps.
  - The freeze cycle and FLUSH do not count.
- **Reset mid-operation:** `rst` in any state returns to RUN next cycle. Any pending FLUSH is abandoned; no `flush` pulse is emitted.

## Timing
- **`stall`:** combinational from the requests and the current state, so it takes effect in the same cycle.
- **`flush` and `new_pc`:**
  - Registered.
  - `excp_req` sampled at edge N gives `flush`=1 during cycle N+1; `new_pc` is valid in that same cycle.
- **Counters:** `stall_timeout` and `stall_cycles` are registered and update on the edge that ends the counted cycle.
- **Reset values** (on the edge with `rst`=1):
  - `stall`=0
  - `flush`=0
  - `new_pc`=32'h0
  - `stall_timeout`=0
  - `stall_cycles`=0
  - watchdog counter 0
  - state RUN
- While `rst`=1, `stall` is forced to 0 regardless of requests.
- **Recovery length:** an exception costs exactly 3 cycles (freeze, FLUSH, REFILL) before `excp_req` is accepted again.

## Test plan
- **Priority:** hold `stallreq_if`=`stallreq_ex`=1 for 3 cycles → `stall`=6'b001111 each cycle; `stall_cycles`=3 afterward.
- **Exception sequence:** `excp_req`=1 with `stallreq_mem`=1, `excp_handler`=32'h0000_0180 → cycle N `stall`=6'b111111; N+1 `flush`=1, `new_pc`=32'h180, `stall`=0; N+2 `excp_req`=1 is ignored; `stall_cycles` unchanged.
- **Watchdog:** with `STALL_LIMIT`=4, hold `stallreq_mem`=1 for 3 cycles then drop for 1 cycle, then hold 4 more → `stall_timeout` rises only after the 4th cycle of the second burst and stays 1 after requests drop.
- **Saturation:** with `CNT_W`=3, hold `stallreq_id`=1 for 10 cycles → `stall_cycles` reaches 3'b111 and holds.
- **Reset mid-recovery:** assert `rst` in the FLUSH cycle → next cycle `flush`=0, all outputs at reset values; a new `excp_req` in the first cycle after reset is accepted (freeze issued).
- **Stall in REFILL:** `stallreq_ex`=1 during REFILL → `stall`=6'b001111 that cycle; the watchdog counts 1.
